// File: rtl/prewitt_stream.sv
// prewitt_stream -- streaming 3x3 Prewitt edge detector.
//
// Accepts a raster-order pixel stream, keeps the two previous rows in line
// buffers and emits one edge-magnitude pixel per input pixel through a single
// backpressured output register. Border outputs are forced to zero.
//
// Optional feature: define PREWITT_THRESH_EN to add the `thresh` port and turn
// non-border outputs into a binary edge map (all-ones when magnitude >= thresh).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       magnitude combine mode, latched at the first pixel of a frame
//   thresh     (PREWITT_THRESH_EN only) edge threshold, latched with mode
//   in_valid   input pixel valid
//   in_ready   block accepts the pixel this cycle
//   in_pixel   input pixel, raster order
//   out_valid  output pixel valid
//   out_ready  downstream accepts the output pixel
//   out_pixel  edge magnitude
//   out_last   high with the final output pixel of a frame
//   busy       high whenever the block is not idle
module prewitt_stream #(
    parameter int PIX_W = 8,
    parameter int COLS  = 500,
    parameter int ROWS  = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
`ifdef PREWITT_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int FW = $clog2(COLS + 2);
    localparam int SW = PIX_W + 2;   // unsigned row/column sums
    localparam int GW = PIX_W + 3;   // signed gradients
    localparam int MW = PIX_W + 4;   // combined magnitude before saturation

    localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);
    localparam logic [FW-1:0]    FLUSH_N  = FW'(COLS + 1);
    localparam logic [PIX_W-1:0] PIX_MAX  = '1;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t           state;
    logic [CW-1:0]    in_col;
    logic [RW-1:0]    in_row;
    logic [FW-1:0]    flush_cnt;
    logic [1:0]       mode_q;
`ifdef PREWITT_THRESH_EN
    logic [PIX_W-1:0] thresh_q;
`endif

    // Line buffers hold rows r-1 (lb1) and r-2 (lb2); window registers hold
    // columns c-2 (win_a) and c-1 (win_b), row 0 being the oldest row.
    logic [PIX_W-1:0] lb1 [COLS];
    logic [PIX_W-1:0] lb2 [COLS];
    logic [PIX_W-1:0] win_a [3];
    logic [PIX_W-1:0] win_b [3];
    logic [PIX_W-1:0] new_col [3];

    logic in_fire, out_fire, produce, last_pix, border;

    assign in_ready = rst_n && (state != FLUSH) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_pix = (in_row == ROW_LAST) && (in_col == COL_LAST);
    // Input (r,c) yields output (r-1,c-1); in_col==0 wraps to column COLS-1 of
    // an earlier row, so it is a border pixel like column 0 and row 0.
    assign border   = (in_col <= CW'(1)) || (in_row == RW'(1));
    assign produce  = (state == RUN) ||
                      (state == FILL && in_row == RW'(1) && in_col == CW'(1));

    logic [SW-1:0]        top_sum, bot_sum, left_sum, right_sum;
    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        ax, ay, px, py;
    logic [MW-1:0]        mag_wide;
    logic [PIX_W-1:0]     mag, result;

    // NOTE: every always_comb output gets a default value on every path, so no
    // latch can be inferred when a case arm is missing.
    always_comb begin
        new_col[0] = lb2[in_col];
        new_col[1] = lb1[in_col];
        new_col[2] = in_pixel;

        top_sum   = SW'(win_a[0]) + SW'(win_b[0]) + SW'(new_col[0]);
        bot_sum   = SW'(win_a[2]) + SW'(win_b[2]) + SW'(new_col[2]);
        left_sum  = SW'(win_a[0]) + SW'(win_a[1]) + SW'(win_a[2]);
        right_sum = SW'(new_col[0]) + SW'(new_col[1]) + SW'(new_col[2]);

        gx = $signed({1'b0, top_sum})  - $signed({1'b0, bot_sum});
        gy = $signed({1'b0, left_sum}) - $signed({1'b0, right_sum});

        ax = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        px = gx[GW-1] ? '0 : $unsigned(gx);
        py = gy[GW-1] ? '0 : $unsigned(gy);

        case (mode_q)
            2'd0:    mag_wide = MW'(px) + MW'(py);
            2'd2:    mag_wide = MW'((ax > ay) ? ax : ay);
            default: mag_wide = MW'(ax) + MW'(ay);   // modes 1 and 3
        endcase

        mag = (mag_wide > MW'(PIX_MAX)) ? PIX_MAX : mag_wide[PIX_W-1:0];

        result = '0;
        if (!border) begin
`ifdef PREWITT_THRESH_EN
            result = (mag >= thresh_q) ? PIX_MAX : '0;
`else
            result = mag;
`endif
        end
    end

    // NOTE: line buffers and window registers are storage with don't-care
    // contents after reset; leaving them unreset lets them map to plain RAM
    // and flops without reset routing. Border forcing hides stale data.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            lb2[in_col] <= lb1[in_col];
            lb1[in_col] <= in_pixel;
            for (int i = 0; i < 3; i++) begin
                win_a[i] <= win_b[i];
                win_b[i] <= new_col[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so later
    // statements in this block see the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_col    <= '0;
            in_row    <= '0;
            flush_cnt <= '0;
            mode_q    <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef PREWITT_THRESH_EN
            thresh_q  <= '0;
`endif
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (in_fire) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
                if (produce) begin
                    out_valid <= 1'b1;
                    out_pixel <= result;
                    out_last  <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (in_fire) begin
                        mode_q <= mode;
`ifdef PREWITT_THRESH_EN
                        thresh_q <= thresh;
`endif
                        state  <= FILL;
                        busy   <= 1'b1;
                    end
                end
                FILL: begin
                    if (in_fire && in_row == RW'(1) && in_col == CW'(1))
                        state <= RUN;
                end
                RUN: begin
                    if (in_fire && last_pix) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    // Remaining outputs are the bottom border row plus the
                    // right border pixel of the row above: all zero.
                    if (flush_cnt != FLUSH_N && (!out_valid || out_ready)) begin
                        out_valid <= 1'b1;
                        out_pixel <= '0;
                        out_last  <= (flush_cnt == FLUSH_N - FW'(1));
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                    if (out_fire && out_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prewitt_stream.sv
// tb_prewitt_stream -- table-driven bench for prewitt_stream on a 4x5 frame.
// Each vector holds a frame, a mode and the six hand-computed interior
// outputs (rows 1-2, cols 1-3); every other output is a border pixel and 0.
module tb_prewitt_stream;

    localparam int PIX_W = 8;
    localparam int COLS  = 5;
    localparam int ROWS  = 4;
    localparam int NPIX  = ROWS * COLS;
    localparam int NVEC  = 13;
    localparam int THR   = 50;

    typedef logic [NPIX-1:0][7:0] frame_t;
    typedef logic [5:0][7:0]      interior_t;

    typedef struct packed {
        logic [8*12-1:0] name;
        logic [1:0]      mode;
        frame_t          pix;
        interior_t       exp_int;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PIX_W-1:0] out_pixel;
    logic             out_last;
    logic             busy;
`ifdef PREWITT_THRESH_EN
    logic [PIX_W-1:0] thresh = '0;
`endif

    always #5 clk = ~clk;

    prewitt_stream #(.PIX_W(PIX_W), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
`ifdef PREWITT_THRESH_EN
        .thresh    (thresh),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_last  (out_last),
        .busy      (busy)
    );

    int   checks   = 0;
    int   failures = 0;
    vec_t vec [NVEC];
    int   got_pix  [NPIX];
    int   got_last [NPIX];
    int   n_got;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Columns below `split` get lv, the rest rv.
    function automatic frame_t frame_cols(input int split, input int lv, input int rv);
        frame_t f;
        for (int i = 0; i < NPIX; i++) f[i] = ((i % COLS) < split) ? 8'(lv) : 8'(rv);
        return f;
    endfunction

    // Zero frame with a single pixel of value v at (r,c).
    function automatic frame_t frame_point(input int r, input int c, input int v);
        frame_t f;
        f = '0;
        f[r * COLS + c] = 8'(v);
        return f;
    endfunction

    function automatic interior_t interior(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5);
        interior_t x;
        x[0] = 8'(a0); x[1] = 8'(a1); x[2] = 8'(a2);
        x[3] = 8'(a3); x[4] = 8'(a4); x[5] = 8'(a5);
        return x;
    endfunction

    function automatic int expected_at(input int v, input int j);
        int r, c, e;
        r = j / COLS;
        c = j % COLS;
        if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 0;
        e = int'(vec[v].exp_int[(r - 1) * 3 + (c - 1)]);
`ifdef PREWITT_THRESH_EN
        e = (e >= THR) ? 255 : 0;
`endif
        return e;
    endfunction

    task automatic set_vec(input int v, input string nm, input int m,
                           input frame_t f, input interior_t e);
        vec[v].name    = 96'(nm);
        vec[v].mode    = 2'(m);
        vec[v].pix     = f;
        vec[v].exp_int = e;
    endtask

    // Streams one frame; mode/thresh are only correct for the first pixel so
    // that later changes must be ignored by the block.
    task automatic run_frame(input int v, input int rdy_pct, input int gap_pct);
        int         idx, cyc;
        logic       held, held_last;
        logic [7:0] held_pix;
        string      nm;
        nm = $sformatf("%0s r%0d", vec[v].name, rdy_pct);
        idx = 0; cyc = 0; n_got = 0;
        held = 1'b0; held_pix = '0; held_last = 1'b0;
        while (n_got < NPIX && cyc < 1000) begin
            @(negedge clk);
            in_valid = (idx < NPIX) && ($urandom_range(99) >= gap_pct);
            if (idx < NPIX) in_pixel = vec[v].pix[idx];
            mode = (idx == 0) ? vec[v].mode : ~vec[v].mode;
`ifdef PREWITT_THRESH_EN
            thresh = (idx == 0) ? 8'(THR) : 8'd200;
`endif
            out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (held) begin
                check({nm, " stall valid"}, int'(out_valid), 1);
                check({nm, " stall pixel"}, int'(out_pixel), int'(held_pix));
                check({nm, " stall last"}, int'(out_last), int'(held_last));
            end
            if (out_valid && out_ready) begin
                got_pix[n_got]  = int'(out_pixel);
                got_last[n_got] = int'(out_last);
                n_got++;
            end
            held      = out_valid && !out_ready;
            held_pix  = out_pixel;
            held_last = out_last;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check({nm, " output count"}, n_got, NPIX);
        check({nm, " busy after"}, int'(busy), 0);
        check({nm, " no extra out"}, int'(out_valid), 0);
        for (int j = 0; j < n_got; j++) begin
            check($sformatf("%0s pix%0d", nm, j), got_pix[j], expected_at(v, j));
            check($sformatf("%0s last%0d", nm, j), got_last[j], (j == NPIX - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int idx, cyc;

        set_vec(0,  "const100",  0, frame_cols(0, 0, 100),  interior(0, 0, 0, 0, 0, 0));
        set_vec(1,  "step200",   0, frame_cols(2, 200, 0),  interior(255, 255, 0, 255, 255, 0));
        set_vec(2,  "step10",    0, frame_cols(2, 10, 0),   interior(30, 30, 0, 30, 30, 0));
        set_vec(3,  "mirror_m0", 0, frame_cols(3, 0, 10),   interior(0, 0, 0, 0, 0, 0));
        set_vec(4,  "mirror_m1", 1, frame_cols(3, 0, 10),   interior(0, 30, 30, 0, 30, 30));
        set_vec(5,  "mirror_m3", 3, frame_cols(3, 0, 10),   interior(0, 30, 30, 0, 30, 30));
        set_vec(6,  "mirror_m2", 2, frame_cols(3, 0, 10),   interior(0, 30, 30, 0, 30, 30));
        set_vec(7,  "diag_m0",   0, frame_point(0, 0, 30),  interior(60, 0, 0, 0, 0, 0));
        set_vec(8,  "diag_m1",   1, frame_point(0, 0, 30),  interior(60, 0, 0, 0, 0, 0));
        set_vec(9,  "diag_m2",   2, frame_point(0, 0, 30),  interior(30, 0, 0, 0, 0, 0));
        set_vec(10, "neg_m0",    0, frame_point(2, 2, 40),  interior(0, 0, 40, 0, 0, 40));
        set_vec(11, "neg_m1",    1, frame_point(2, 2, 40),  interior(80, 40, 80, 40, 0, 40));
        set_vec(12, "neg_m2",    2, frame_point(2, 2, 40),  interior(40, 40, 40, 40, 0, 40));

        // Reset state, with a pixel offered so in_ready is meaningful.
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_last", int'(out_last), 0);
        check("reset busy", int'(busy), 0);
        check("reset out_pixel", int'(out_pixel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        for (int v = 0; v < NVEC; v++) run_frame(v, 100, 0);

        // Backpressure and input gaps must not change the output sequence.
        run_frame(1, 50, 30);
        run_frame(11, 50, 30);
        run_frame(9, 40, 50);

        // Reset after 7 inputs, then a clean frame.
        idx = 0; cyc = 0;
        while (idx < 7 && cyc < 100) begin
            @(negedge clk);
            in_valid = 1'b1; in_pixel = 8'd77; mode = 2'd1; out_ready = 1'b1;
            #1;
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        check("partial accepted", idx, 7);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("partial busy", int'(busy), 1);
        check("partial first out", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset in_ready", int'(in_ready), 0);
        check("midreset out_last", int'(out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        run_frame(1, 100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prewitt_stream.md
Name: prewitt_stream

Overview:
- Streaming 3x3 Prewitt edge detector. It takes a raster-order pixel stream, builds the window from two internal line buffers, and emits one edge-magnitude pixel per input pixel.
- It replaces whole-frame array processing with a backpressured valid/ready pipeline.
- It sits between the image source (file reader or camera front end) and the output writer or labelling stage.

Parameters:
- PIX_W, 8, pixel width in bits; output uses the same width.
- COLS, 500, frame width in pixels; minimum 3.
- ROWS, 500, frame height in pixels; minimum 3.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  magnitude combine mode; sampled at the first pixel of each frame.
- in_valid  input  1  input pixel valid.
- in_ready  output  1  block accepts the pixel this cycle.
- in_pixel  input  PIX_W  input pixel, raster order (row 0, col 0 first).
- out_valid  output  1  output pixel valid.
- out_ready  input  1  downstream accepts the output pixel.
- out_pixel  output  PIX_W  edge magnitude.
- out_last  output  1  high with the final output pixel of a frame.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters, out_valid, out_last and busy are 0; out_pixel=0; in_ready=0 while in reset.
  - Line-buffer contents are don't-care.
- Handshakes:
  - An input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
  - There is one output register. in_ready = (state is IDLE/FILL/RUN) & (!out_valid | out_ready).
  - out_pixel and out_last are held stable while out_valid & !out_ready.
- States:
  - IDLE: in_ready high. The first transfer latches mode, writes pixel 0 and goes to FILL.
  - FILL: accepts inputs and produces no outputs until input index COLS+1 (pixel (1,1)) has been accepted, then goes to RUN.
  - RUN:
    - Each accepted input at index k produces output index k-(COLS+1).
    - When the input at index ROWS*COLS-1 is accepted, the state goes to FLUSH.
  - FLUSH: in_ready=0. Emits the remaining COLS+1 outputs, all zero (all are border pixels). Returns to IDLE on the transfer with out_last=1.
- Latency: output (r,c) becomes valid one cycle after input (r+1,c+1) is accepted, given no backpressure.
- Border: any output with r=0, r=ROWS-1, c=0 or c=COLS-1 is 0.
- Window wrap: column wrap-around never mixes pixels from adjacent rows, because border outputs are forced to 0.
- Arithmetic:
  - Row and column sums are PIX_W+2 bits unsigned.
  - gx = (top-row sum) - (bottom-row sum).
  - gy = (left-column sum) - (right-column sum).
  - gx and gy are signed PIX_W+3 bits.
- Mode (latched per frame):
  - 0: negative gx and gy are clamped to 0, then summed.
  - 1: |gx| + |gy|.
  - 2: max(|gx|, |gy|).
  - 3: reserved, behaves as 1.
- Saturation: the result saturates to 2^PIX_W-1.
- Mode changes mid-frame have no effect until the next frame.
- Reset mid-frame: everything aborts immediately. The next accepted pixel is treated as pixel (0,0).
- in_valid deasserted mid-frame: the block stalls indefinitely with no timeout; counters hold.

Optional Feature:
- Macro PREWITT_THRESH_EN.
- When defined:
  - Adds input port thresh [PIX_W-1:0], latched with mode at frame start.
  - Non-border outputs become 2^PIX_W-1 if magnitude >= thresh, else 0 (binary edge map).
- When undefined: no thresh port; the magnitude is output directly.

Test Plan:
- Constant frame, ROWS=4, COLS=5, all pixels 100, mode 0, out_ready=1 -> 20 outputs, all 0; out_last only on the 20th; busy falls after it.
- Vertical step, cols 0-1=200, cols 2-4=0, mode 0 -> (1,1),(1,2),(2,1),(2,2)=255 (gy=600 saturated); (1,3),(2,3)=0; borders 0.
- Step with left 10, right 0 at cols 0-1/2-4 -> gy=30 -> mode 0 gives 30 at (1,1),(1,2). Mirrored step (left 0, right 10) -> mode 0 gives 0 at (1,2),(1,3); mode 1 gives 30.
- Diagonal giving gx=30, gy=30 -> mode 0/1 output 60, mode 2 output 30. With PREWITT_THRESH_EN and thresh=50: mode 1 outputs 255, mode 2 outputs 0.
- Random out_ready (50%) with random in_valid gaps -> output sequence identical to the no-stall run; no pixel dropped or duplicated; out_pixel stable while stalled.
- rst_n pulsed low after 7 inputs, then a full constant frame -> outputs match a clean run; exactly 20 outputs; no stale out_valid after reset.
